// File: rtl/regfile_rename_if.sv
// ---------------------------------------------------------------------------
// regfile_rename_if
//
// Purpose:
//   Bundles every non-clock/reset signal of the renaming register file so the
//   dispatch/commit side and the register file share one connection object.
//
// Signal summary:
//   rdy      global ready; low freezes all register-file state
//   rd_addr  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data  packed read values, port k at [k*DATA_W +: DATA_W]
//   rd_busy  per-port pending flag; rd_tag is meaningful when set
//   rd_tag   packed producer ROB tags, port k at [k*TAG_W +: TAG_W]
//   ren_*    rename request: destination register and its new ROB tag
//   cm_*     commit write: destination, committing ROB tag and value
//   flush    mispredict; discards all rename state
//
// Modports:
//   master   dispatch/commit logic driving requests and consuming reads
//   slave    the register file itself
// ---------------------------------------------------------------------------
interface regfile_rename_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int TAG_W  = 4,
    parameter int N_RD   = 2
);

    logic                     rdy;
    logic [N_RD*ADDR_W-1:0]   rd_addr;
    logic [N_RD*DATA_W-1:0]   rd_data;
    logic [N_RD-1:0]          rd_busy;
    logic [N_RD*TAG_W-1:0]    rd_tag;
    logic                     ren_en;
    logic [ADDR_W-1:0]        ren_rd;
    logic [TAG_W-1:0]         ren_tag;
    logic                     cm_en;
    logic [ADDR_W-1:0]        cm_rd;
    logic [TAG_W-1:0]         cm_tag;
    logic [DATA_W-1:0]        cm_data;
    logic                     flush;

    // The requesting side: drives addresses, rename and commit traffic.
    modport master (
        output rdy,
        output rd_addr,
        input  rd_data,
        input  rd_busy,
        input  rd_tag,
        output ren_en,
        output ren_rd,
        output ren_tag,
        output cm_en,
        output cm_rd,
        output cm_tag,
        output cm_data,
        output flush
    );

    // The register file: answers reads and absorbs rename/commit traffic.
    modport slave (
        input  rdy,
        input  rd_addr,
        output rd_data,
        output rd_busy,
        output rd_tag,
        input  ren_en,
        input  ren_rd,
        input  ren_tag,
        input  cm_en,
        input  cm_rd,
        input  cm_tag,
        input  cm_data,
        input  flush
    );

endinterface

// File: rtl/regfile_rename.sv
// ---------------------------------------------------------------------------
// regfile_rename
//
// Purpose:
//   Architectural register file for the out-of-order core. Every register
//   carries a busy bit and the ROB tag of its in-flight producer. Reads are
//   combinational with a commit bypass; rename and commit update state on
//   the rising clock edge; flush drops all rename state.
//
// Ports:
//   clk   clock; all state updates on the rising edge
//   rst   synchronous active-high reset; clears data, busy bits and tags
//         and forces all read outputs to zero while asserted
//   bus   regfile_rename_if.slave carrying rdy, N_RD read ports, the rename
//         port, the commit port and flush
//
// Notes:
//   Register 0 is hard-wired: it reads as data 0, not busy, and ignores
//   renames and commits.
//   Edge priority for busy/tag: rst > rdy low > flush > rename > commit.
//   Commit data is written whenever cm_en is set, except under rst or rdy low.
// ---------------------------------------------------------------------------
module regfile_rename #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int TAG_W  = 4,
    parameter int N_RD   = 2
) (
    input  logic               clk,
    input  logic               rst,
    regfile_rename_if.slave    bus
);

    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0] r_regs [NREG];
    logic [NREG-1:0]   r_busy;
    logic [TAG_W-1:0]  r_tag  [NREG];

    logic              w_cmWrite;
    logic              w_renWrite;
    logic              w_cmClear;
    logic [ADDR_W-1:0] w_rdAddr;
    logic              w_cmHit;

    // Decode the rename and commit requests once. Anything aimed at register
    // 0 is dropped here so the storage logic never has to think about it.
    // A commit only retires the rename state if the register is still waiting
    // on exactly this producer; a younger rename of the same register in the
    // same cycle keeps it busy under the new tag.
    assign w_cmWrite  = bus.cm_en  && (bus.cm_rd  != '0);
    assign w_renWrite = bus.ren_en && (bus.ren_rd != '0);
    assign w_cmClear  = w_cmWrite
                        && r_busy[bus.cm_rd]
                        && (r_tag[bus.cm_rd] == bus.cm_tag)
                        && !(w_renWrite && (bus.ren_rd == bus.cm_rd));

    // Storage update. Reset clears everything; rdy low freezes everything.
    // The committed value always lands in the data array, even alongside a
    // flush or a rename of the same register, because it is the newest
    // architectural value. Flush then wipes every busy bit and tag and
    // swallows any rename issued with it. Otherwise a rename marks its
    // destination busy, and a matching commit clears busy and tag so the
    // stored state matches what the bypass path showed in the commit cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
                r_tag[i]  <= '0;
            end
            r_busy <= '0;
        end else if (bus.rdy) begin
            if (w_cmWrite) begin
                r_regs[bus.cm_rd] <= bus.cm_data;
            end
            if (bus.flush) begin
                r_busy <= '0;
                for (int i = 0; i < NREG; i++) begin
                    r_tag[i] <= '0;
                end
            end else begin
                if (w_renWrite) begin
                    r_busy[bus.ren_rd] <= 1'b1;
                    r_tag[bus.ren_rd]  <= bus.ren_tag;
                end
                if (w_cmClear) begin
                    r_busy[bus.cm_rd] <= 1'b0;
                    r_tag[bus.cm_rd]  <= '0;
                end
            end
        end
    end

    // Read ports. Each port looks up its register and, if a commit to the
    // same register is happening this cycle, returns the committed value
    // instead of the stored one. The busy/tag pair is only retired by the
    // bypass when the commit is from the producer the register is waiting
    // on; a stale commit updates the value but leaves the register pending.
    // A rename in the same cycle is deliberately invisible here so that a
    // µop reading and writing the same register sees the old producer.
    // Reset and rdy low both force every port to all zeros.
    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        bus.rd_tag  = '0;
        w_rdAddr    = '0;
        w_cmHit     = 1'b0;
        for (int k = 0; k < N_RD; k++) begin
            w_rdAddr = bus.rd_addr[k*ADDR_W +: ADDR_W];
            w_cmHit  = bus.cm_en && (bus.cm_rd == w_rdAddr);
            if (!rst && bus.rdy && (w_rdAddr != '0)) begin
                if (w_cmHit) begin
                    bus.rd_data[k*DATA_W +: DATA_W] = bus.cm_data;
                end else begin
                    bus.rd_data[k*DATA_W +: DATA_W] = r_regs[w_rdAddr];
                end
                if (w_cmHit && r_busy[w_rdAddr]
                    && (r_tag[w_rdAddr] == bus.cm_tag)) begin
                    bus.rd_busy[k]                = 1'b0;
                    bus.rd_tag[k*TAG_W +: TAG_W]  = '0;
                end else begin
                    bus.rd_busy[k]                = r_busy[w_rdAddr];
                    bus.rd_tag[k*TAG_W +: TAG_W]  = r_tag[w_rdAddr];
                end
            end
        end
    end

endmodule

// File: doc/regfile_rename.md
Name: regfile_rename

Overview:
Parametrised architectural register file for the out-of-order core, successor to the in-order register file. It adds per-register rename state: a busy bit and a reorder-buffer tag naming the in-flight producer. The file has N_RD combinational read ports, one rename (issue) port, one commit (write) port and a global flush. It sits between decode/dispatch (read and rename) and ROB commit (write).

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width; NREG = 2**ADDR_W registers
TAG_W, 4, ROB tag width
N_RD, 2, number of read ports

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; when low, all state frozen
rd_addr  in  N_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W]
rd_data  out  N_RD*DATA_W  read values
rd_busy  out  N_RD  1 = value pending; rd_tag is valid
rd_tag  out  N_RD*TAG_W  producer ROB tag when rd_busy
ren_en  in  1  rename request
ren_rd  in  ADDR_W  destination register being renamed
ren_tag  in  TAG_W  ROB tag of the new producer
cm_en  in  1  commit write
cm_rd  in  ADDR_W  committed destination
cm_tag  in  TAG_W  ROB tag of the committing entry
cm_data  in  DATA_W  committed value
flush  in  1  mispredict: discard all rename state

Behaviour:
- Reset is a clock edge with rst=1. All regs, busy bits and tags clear to 0. While rst=1, every read port returns rd_data=0, rd_busy=0 and rd_tag=0. rst has priority over every other input.
- rdy=0: no state changes. Read outputs are forced to 0, matching reset.
- Register 0: always reads data=0 and busy=0. Writes, renames and commits to register 0 are ignored.
- Read (combinational, per port k, rdy=1):
  - Default: data=regs[a], busy=busy[a], tag=tag[a].
  - Commit bypass: if cm_en, cm_rd==a, busy[a]=1 and tag[a]==cm_tag, then data=cm_data, busy=0, tag=0.
  - Commit to the same address with a non-matching tag: data=cm_data, busy and tag unchanged (the value is stale-but-newest architectural).
  - Rename in the same cycle does NOT affect reads. Sources are read before the destination is renamed.
- Commit (edge, cm_en=1, cm_rd!=0): regs[cm_rd] <= cm_data always. busy[cm_rd] clears only if tag[cm_rd]==cm_tag and no rename targets cm_rd this cycle.
- Rename (edge, ren_en=1, ren_rd!=0): busy[ren_rd] <= 1 and tag[ren_rd] <= ren_tag.
- Rename and commit to the same register in one cycle: rename wins for busy and tag. Data is still written.
- Flush (edge): all busy bits and tags clear to 0. A simultaneous commit still writes its data. A simultaneous rename is dropped. Flush outranks rename.
- Priority per edge: rst > rdy=0 (hold) > flush > rename > commit for busy/tag. Commit data is written whenever cm_en=1, except under rst or rdy=0.
- Latency: rename and commit are visible on the reads the cycle after the edge. The commit value is also visible in the same cycle via bypass.
- Read ports are independent. All N_RD ports may address the same register.

Test Plan:
- Reset: apply rst 1 cycle after random writes -> all ports read data=0 and busy=0 for every address, including during rst.
- Rename then commit: ren x5 tag=3; next cycle read x5 -> busy=1, tag=3. Commit x5 tag=3 data=0xDEADBEEF -> same-cycle read gives data=0xDEADBEEF, busy=0; next cycle identical from storage.
- Stale commit: ren x7 tag=2, ren x7 tag=6, commit x7 tag=2 data=0x11 -> x7 data=0x11, busy=1, tag=6.
- Same-cycle rename+commit on x9: ren tag=4, cm tag=1 (matching old tag) data=0x55 -> after edge data=0x55, busy=1, tag=4. Same-cycle read showed data=0x55, busy=0.
- Flush: rename x1..x31 tags, assert flush with ren x3 and commit x4 data=0x77 -> all busy=0, x3 not busy, x4=0x77.
- x0 and rdy: ren/commit to x0 -> reads 0, not busy. With rdy=0, rename/commit x8 -> no change after rdy returns to 1. Exercise with N_RD=4 and all ports reading the same address.
